// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card qualification, PIN retry limit, menu/amount
// selection, balance check and dispenser req/ack handshake.
module atm_session_ctrl #(
   parameter int BAL_W     = 16,
   parameter int INIT_BAL  = 20,
   parameter int MAX_TRIES = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             card,
   input  logic             pin_valid,
   input  logic             pin_ok,
   input  logic             choice,
   input  logic             choice_valid,
   input  logic [1:0]       amount,
   input  logic             amount_valid,
   input  logic             disp_ack,
   output logic             disp_req,
   output logic             disp_dir,
   output logic [1:0]       disp_amount,
   output logic [BAL_W-1:0] balance,
   output logic             card_eject,
   output logic             card_retain,
   output logic             insufficient,
   output logic [2:0]       state_o
);

   // state    | meaning
   // S_IDLE   | no session, waiting for a card insertion edge
   // S_PIN    | waiting for PIN entry, counting wrong attempts
   // S_MENU   | waiting for deposit/withdraw choice
   // S_AMOUNT | waiting for amount selection, funds check on withdraw
   // S_DISP   | disp_req held until disp_ack, then balance updated
   // S_EJECT  | card ejected, waiting for card removal
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PIN    = 3'd1,
      S_MENU   = 3'd2,
      S_AMOUNT = 3'd3,
      S_DISP   = 3'd4,
      S_EJECT  = 3'd5
   } state_t;

   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int TRW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0]    TMO      = TW'(TIMEOUT);
   localparam logic [TRW-1:0]   TRY_LIM  = TRW'(MAX_TRIES);
   localparam logic [BAL_W-1:0] BAL_INIT = BAL_W'(INIT_BAL);

   state_t           state_q;
   logic [TRW-1:0]   tries_q;
   logic [TW-1:0]    timer_q;
   logic             card_q;
   logic             armed_q;
   logic [BAL_W-1:0] balance_q;
   logic             disp_req_q;
   logic             disp_dir_q;
   logic [1:0]       disp_amount_q;
   logic             card_eject_q;
   logic             card_retain_q;
   logic             insufficient_q;

   logic [2:0]       amt_units;
   logic [2:0]       disp_units;
   logic [BAL_W:0]   bal_sum;
   logic [BAL_W-1:0] bal_add_d;
   logic [BAL_W-1:0] bal_sub_d;
   logic             short_funds;
   logic [TRW-1:0]   tries_d;
   logic             card_rise;
   logic             timed_out;

   function automatic logic [2:0] units_of(input logic [1:0] code);
      case (code)
         2'b01:   units_of = 3'd1;
         2'b10:   units_of = 3'd2;
         2'b11:   units_of = 3'd4;
         default: units_of = 3'd0;
      endcase
   endfunction

   always_comb begin
      amt_units   = units_of(amount);
      disp_units  = units_of(disp_amount_q);
      bal_sum     = {1'b0, balance_q} + (BAL_W+1)'(disp_units);
      bal_add_d   = bal_sum[BAL_W] ? '1 : bal_sum[BAL_W-1:0];
      bal_sub_d   = balance_q - BAL_W'(disp_units);
      short_funds = (BAL_W+3)'(amt_units) > {3'b000, balance_q};
      tries_d     = tries_q + TRW'(1);
      // armed_q masks a card that was already present when reset released
      card_rise   = card & ~card_q & armed_q;
      timed_out   = (timer_q == TMO);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         tries_q        <= '0;
         timer_q        <= '0;
         card_q         <= 1'b0;
         armed_q        <= 1'b0;
         balance_q      <= BAL_INIT;
         disp_req_q     <= 1'b0;
         disp_dir_q     <= 1'b0;
         disp_amount_q  <= 2'b00;
         card_eject_q   <= 1'b0;
         card_retain_q  <= 1'b0;
         insufficient_q <= 1'b0;
      end else begin
         card_q         <= card;
         armed_q        <= 1'b1;
         card_eject_q   <= 1'b0;
         card_retain_q  <= 1'b0;
         insufficient_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (card_rise) begin
                  state_q <= S_PIN;
                  tries_q <= '0;
                  timer_q <= '0;
               end
            end
            S_PIN: begin
               if (!card) begin
                  state_q <= S_IDLE;
                  timer_q <= '0;
               end else if (timed_out) begin
                  state_q      <= S_EJECT;
                  card_eject_q <= 1'b1;
                  timer_q      <= '0;
               end else if (pin_valid) begin
                  timer_q <= '0;
                  if (pin_ok) begin
                     state_q <= S_MENU;
                  end else if (tries_d == TRY_LIM) begin
                     state_q       <= S_IDLE;
                     card_retain_q <= 1'b1;
                     tries_q       <= '0;
                  end else begin
                     tries_q <= tries_d;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_MENU: begin
               if (!card) begin
                  state_q <= S_IDLE;
                  timer_q <= '0;
               end else if (timed_out) begin
                  state_q      <= S_EJECT;
                  card_eject_q <= 1'b1;
                  timer_q      <= '0;
               end else if (choice_valid) begin
                  disp_dir_q <= choice;
                  state_q    <= S_AMOUNT;
                  timer_q    <= '0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_AMOUNT: begin
               if (!card) begin
                  state_q <= S_IDLE;
                  timer_q <= '0;
               end else if (timed_out) begin
                  state_q      <= S_EJECT;
                  card_eject_q <= 1'b1;
                  timer_q      <= '0;
               end else if (amount_valid) begin
                  timer_q <= '0;
                  if (amount == 2'b00) begin
                     state_q      <= S_EJECT;
                     card_eject_q <= 1'b1;
                  end else if (disp_dir_q && short_funds) begin
                     insufficient_q <= 1'b1;
                  end else begin
                     disp_amount_q <= amount;
                     disp_req_q    <= 1'b1;
                     state_q       <= S_DISP;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_DISP: begin
               if (disp_ack) begin
                  disp_req_q   <= 1'b0;
                  balance_q    <= disp_dir_q ? bal_sub_d : bal_add_d;
                  state_q      <= S_EJECT;
                  card_eject_q <= 1'b1;
               end
            end
            S_EJECT: begin
               if (!card) state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

   assign disp_req     = disp_req_q;
   assign disp_dir     = disp_dir_q;
   assign disp_amount  = disp_amount_q;
   assign balance      = balance_q;
   assign card_eject   = card_eject_q;
   assign card_retain  = card_retain_q;
   assign insufficient = insufficient_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: vector table for the basic session and
// PIN lockout, hand sequences for funds, saturation, timeout and reset cases.
module tb_atm_session_ctrl;
   localparam int BAL_W = 5;   // narrow balance so saturation is reachable quickly
   localparam int TO    = 255;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             card = 1'b0, pin_valid = 1'b0, pin_ok = 1'b0;
   logic             choice = 1'b0, choice_valid = 1'b0;
   logic [1:0]       amount = 2'b00;
   logic             amount_valid = 1'b0, disp_ack = 1'b0;
   logic             disp_req, disp_dir, card_eject, card_retain, insufficient;
   logic [1:0]       disp_amount;
   logic [BAL_W-1:0] balance;
   logic [2:0]       state_o;

   int checks = 0;
   int errors = 0;

   atm_session_ctrl #(.BAL_W(BAL_W), .INIT_BAL(20), .MAX_TRIES(3), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .card(card), .pin_valid(pin_valid), .pin_ok(pin_ok),
      .choice(choice), .choice_valid(choice_valid), .amount(amount),
      .amount_valid(amount_valid), .disp_ack(disp_ack), .disp_req(disp_req),
      .disp_dir(disp_dir), .disp_amount(disp_amount), .balance(balance),
      .card_eject(card_eject), .card_retain(card_retain), .insufficient(insufficient),
      .state_o(state_o));

   always #5 clock = ~clock;

   typedef struct {
      logic       card, pv, pok, ch, cv;
      logic [1:0] amt;
      logic       av, ack;
      logic [2:0] st;
      logic       req, dir;
      logic [1:0] damt;
      logic       ej, rt, ins;
      logic [4:0] bal;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_strobes();
      pin_valid = 0; pin_ok = 0; choice_valid = 0; choice = 0;
      amount_valid = 0; amount = 2'b00; disp_ack = 0;
   endtask

   // full session: insert, good PIN, choose, select, immediate ack, remove
   task automatic session(input logic dir, input logic [1:0] amt, input int exp_bal);
      card = 1; tick(); chk("sess_pin", state_o, 1);
      pin_valid = 1; pin_ok = 1; tick(); clr_strobes(); chk("sess_menu", state_o, 2);
      choice_valid = 1; choice = dir; tick(); clr_strobes(); chk("sess_amount", state_o, 3);
      amount_valid = 1; amount = amt; tick(); clr_strobes();
      chk("sess_disp", {state_o, disp_req, disp_dir, disp_amount}, {3'd4, 1'b1, dir, amt});
      disp_ack = 1; tick(); clr_strobes();
      chk("sess_done", {state_o, disp_req, card_eject, balance}, {3'd5, 1'b0, 1'b1, 5'(exp_bal)});
      card = 0; tick(); chk("sess_idle", state_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [14:0] act, exp;
      //               card pv pok ch cv amt  av ack   st  req dir damt ej rt ins bal
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd1,0,0,2'b00,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,1,1,0,0,2'b00,0,0, 3'd2,0,0,2'b00,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,0,0,1,1,2'b00,0,0, 3'd3,0,1,2'b00,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b10,1,0, 3'd4,1,1,2'b10,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd4,1,1,2'b10,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd4,1,1,2'b10,0,0,0,5'd20});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,1, 3'd5,0,1,2'b10,1,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd5,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{0,0,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{0,0,0,0,0,2'b00,0,1, 3'd0,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,1,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{0,0,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,0,0,2'b00,0,0, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,1,2'b01,1,1, 3'd1,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,1,0,0,2'b01,1,0, 3'd2,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b01,1,1, 3'd2,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,0,1,1,2'b00,0,0, 3'd3,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,1,1,0,1,2'b00,0,0, 3'd3,0,1,2'b10,0,0,0,5'd18});
      vecs.push_back(vec_t'{1,0,0,0,0,2'b00,1,0, 3'd5,0,1,2'b10,1,0,0,5'd18});
      vecs.push_back(vec_t'{0,0,0,0,0,2'b00,0,0, 3'd0,0,1,2'b10,0,0,0,5'd18});

      repeat (2) @(posedge clock);
      #2 reset = 1;
      tick(); tick();
      chk("reset_state",
          {state_o, disp_req, disp_dir, disp_amount, card_eject, card_retain, insufficient, balance},
          {3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd20});

      for (int i = 0; i < vecs.size(); i++) begin
         card = vecs[i].card; pin_valid = vecs[i].pv; pin_ok = vecs[i].pok;
         choice = vecs[i].ch; choice_valid = vecs[i].cv; amount = vecs[i].amt;
         amount_valid = vecs[i].av; disp_ack = vecs[i].ack;
         tick();
         act = {state_o, disp_req, disp_dir, disp_amount, card_eject, card_retain, insufficient, balance};
         exp = {vecs[i].st, vecs[i].req, vecs[i].dir, vecs[i].damt, vecs[i].ej, vecs[i].rt,
                vecs[i].ins, vecs[i].bal};
         chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
      end
      clr_strobes(); card = 0;

      // drain 18 -> 2 by withdrawing 4 units at a time
      session(1, 2'b11, 14);
      session(1, 2'b11, 10);
      session(1, 2'b11, 6);
      session(1, 2'b11, 2);

      // insufficient funds, then a smaller withdrawal succeeds
      card = 1; tick();
      pin_valid = 1; pin_ok = 1; tick(); clr_strobes();
      choice_valid = 1; choice = 1; tick(); clr_strobes();
      amount_valid = 1; amount = 2'b11; tick(); clr_strobes();
      chk("insuf_pulse", {state_o, insufficient, disp_req, balance}, {3'd3, 1'b1, 1'b0, 5'd2});
      tick();
      chk("insuf_once", {state_o, insufficient}, {3'd3, 1'b0});
      amount_valid = 1; amount = 2'b01; tick(); clr_strobes();
      chk("insuf_retry", {state_o, disp_req, disp_amount}, {3'd4, 1'b1, 2'b01});
      disp_ack = 1; tick(); clr_strobes();
      chk("insuf_bal", {state_o, card_eject, balance}, {3'd5, 1'b1, 5'd1});
      card = 0; tick();

      // deposits 1 -> 29, then saturate at 31
      for (int k = 1; k <= 7; k++) session(0, 2'b11, 1 + 4 * k);
      session(0, 2'b11, 31);
      session(0, 2'b01, 31);

      // menu timeout
      card = 1; tick();
      pin_valid = 1; pin_ok = 1; tick(); clr_strobes();
      n = 0;
      repeat (250) begin tick(); n++; end
      chk("tmo_early", state_o, 2);
      while (state_o != 3'd5 && n < 300) begin tick(); n++; end
      chk("tmo_state", state_o, 5);
      chk("tmo_eject", card_eject, 1);
      chk("tmo_cycles", 32'(n >= TO && n <= TO + 1), 1);
      card = 0; tick();
      chk("tmo_idle", state_o, 0);

      // card removed in AMOUNT: no eject pulse
      card = 1; tick();
      pin_valid = 1; pin_ok = 1; tick(); clr_strobes();
      choice_valid = 1; choice = 0; tick(); clr_strobes();
      chk("drop_amount", state_o, 3);
      card = 0; tick();
      chk("drop_idle", {state_o, card_eject}, {3'd0, 1'b0});
      tick();
      chk("drop_noeject", card_eject, 0);

      // reset in the middle of a dispense
      card = 1; tick();
      pin_valid = 1; pin_ok = 1; tick(); clr_strobes();
      choice_valid = 1; choice = 1; tick(); clr_strobes();
      amount_valid = 1; amount = 2'b10; tick(); clr_strobes();
      chk("rst_req_on", {state_o, disp_req}, {3'd4, 1'b1});
      #2 reset = 0;
      #1 chk("rst_async", {state_o, disp_req, balance}, {3'd0, 1'b0, 5'd20});
      @(negedge clock);
      reset = 1;
      disp_ack = 1; tick(); disp_ack = 0;
      tick(); tick();
      chk("rst_after", {state_o, disp_req, card_eject, balance}, {3'd0, 1'b0, 1'b0, 5'd20});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
